// File: rtl/simple_bus_arbiter_if.sv
// Signal bundle between the requesting masters, the arbiter and the single bus slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface simple_bus_arbiter_if #(
  parameter int NUM_M = 4
);
  logic [NUM_M-1:0]   m_req;
  logic [NUM_M-1:0]   m_rw;
  logic [8*NUM_M-1:0] m_addr;
  logic [8*NUM_M-1:0] m_wdata;
  logic [NUM_M-1:0]   m_gnt;
  logic [NUM_M-1:0]   m_valid;
  logic               m_err;
  logic [7:0]         m_rdata;
  logic               s_req;
  logic               s_rw;
  logic [7:0]         s_addr;
  logic [7:0]         s_wdata;
  logic [7:0]         s_rdata;
  logic               s_valid;

  modport slave (
    input  m_req, m_rw, m_addr, m_wdata, s_rdata, s_valid,
    output m_gnt, m_valid, m_err, m_rdata, s_req, s_rw, s_addr, s_wdata
  );

  modport master (
    output m_req, m_rw, m_addr, m_wdata, s_rdata, s_valid,
    input  m_gnt, m_valid, m_err, m_rdata, s_req, s_rw, s_addr, s_wdata
  );
endinterface

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter that serialises NUM_M masters onto one slave bus, one transaction
// in flight, with a per-transaction timeout that answers 8'hFF and raises m_err.
module simple_bus_arbiter #(
  parameter int NUM_M   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  simple_bus_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_M - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_M-1:0]   gnt_q, gnt_d;
  logic [NUM_M-1:0]   valid_q, valid_d;
  logic               err_q, err_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               s_req_q, s_req_d;
  logic               s_rw_q, s_rw_d;
  logic [7:0]         s_addr_q, s_addr_d;
  logic [7:0]         s_wdata_q, s_wdata_d;

  logic               win_found_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [NUM_M-1:0]   win_onehot_s;
  logic               timeout_s;

  // Winner search: first requester strictly after the last-served master, wrapping.
  always_comb begin
    int  cand;
    logic hit;
    win_found_s = 1'b0;
    win_idx_s   = {IDX_W{1'b0}};
    cand        = 0;
    hit         = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      cand        = int'(ptr_q) + k;
      cand        = (cand >= NUM_M) ? (cand - NUM_M) : cand;
      hit         = !win_found_s && bus.m_req[cand[IDX_W-1:0]];
      win_idx_s   = hit ? cand[IDX_W-1:0] : win_idx_s;
      win_found_s = win_found_s | hit;
    end
    win_onehot_s = {{(NUM_M-1){1'b0}}, 1'b1} << win_idx_s;
  end

  assign timeout_s = (cnt_q == CNT_LAST);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = win_found_s ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_d = (bus.s_valid || timeout_s) ? ST_RESP : ST_BUSY;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; a real response takes priority over an expiring timeout.
  always_comb begin
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    s_req_d   = s_req_q;
    s_rw_d    = s_rw_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_s) begin
          gidx_d    = win_idx_s;
          gnt_d     = win_onehot_s;
          cnt_d     = {CNT_W{1'b0}};
          s_req_d   = 1'b1;
          s_rw_d    = bus.m_rw[win_idx_s];
          s_addr_d  = bus.m_addr[{win_idx_s, 3'b000} +: 8];
          s_wdata_d = bus.m_wdata[{win_idx_s, 3'b000} +: 8];
        end else begin
          s_req_d   = 1'b0;
        end
      end
      ST_BUSY: begin
        if (bus.s_valid) begin
          rdata_d = bus.s_rdata;
          valid_d = gnt_q;
          err_d   = 1'b0;
          s_req_d = 1'b0;
          ptr_d   = gidx_q;
        end else if (timeout_s) begin
          rdata_d = 8'hFF;
          valid_d = gnt_q;
          err_d   = 1'b1;
          s_req_d = 1'b0;
          ptr_d   = gidx_q;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_RESP: begin
        valid_d = {NUM_M{1'b0}};
        err_d   = 1'b0;
        gnt_d   = {NUM_M{1'b0}};
      end
      default: begin
        valid_d = {NUM_M{1'b0}};
        err_d   = 1'b0;
        gnt_d   = {NUM_M{1'b0}};
        s_req_d = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered datapath and outputs; reset aborts any transaction without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= PTR_RST;
      gidx_q    <= {IDX_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      gnt_q     <= {NUM_M{1'b0}};
      valid_q   <= {NUM_M{1'b0}};
      err_q     <= 1'b0;
      rdata_q   <= 8'h00;
      s_req_q   <= 1'b0;
      s_rw_q    <= 1'b0;
      s_addr_q  <= 8'h00;
      s_wdata_q <= 8'h00;
    end else begin
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      s_req_q   <= s_req_d;
      s_rw_q    <= s_rw_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  assign bus.m_gnt   = gnt_q;
  assign bus.m_valid = valid_q;
  assign bus.m_err   = err_q;
  assign bus.m_rdata = rdata_q;
  assign bus.s_req   = s_req_q;
  assign bus.s_rw    = s_rw_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Directed scenarios followed by randomized transactions checked against a transaction-level
// model of round-robin selection, slave latency and timeout.
module tb_simple_bus_arbiter;
  localparam int NUM_M   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  simple_bus_arbiter_if #(.NUM_M(NUM_M)) bus ();
  simple_bus_arbiter #(.NUM_M(NUM_M), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int               last_srv;
  logic [NUM_M-1:0] req_v;
  logic             cmd_rw    [NUM_M];
  logic [7:0]       cmd_addr  [NUM_M];
  logic [7:0]       cmd_wdata [NUM_M];
  int               hi, lat, w, c;
  bit               seen, done, exp_err;
  logic [7:0]       rd, exp_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_M-1:0] oh(input int i);
    logic [NUM_M-1:0] v;
    v    = {NUM_M{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int m, input logic rw, input logic [7:0] a, input logic [7:0] d);
    cmd_rw[m]    = rw;
    cmd_addr[m]  = a;
    cmd_wdata[m] = d;
    bus.m_rw[m]  = rw;
    bus.m_addr[8*m +: 8]  = a;
    bus.m_wdata[8*m +: 8] = d;
  endtask

  task automatic drive_req(input logic [NUM_M-1:0] r);
    req_v      = r;
    bus.m_req  = r;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    drive_req({NUM_M{1'b0}});
    bus.m_rw    = {NUM_M{1'b0}};
    bus.m_addr  = {(8*NUM_M){1'b0}};
    bus.m_wdata = {(8*NUM_M){1'b0}};
    bus.s_valid = 1'b0;
    bus.s_rdata = 8'h00;
    tick();
    tick();
    chk("rst_gnt",   32'(bus.m_gnt),   32'd0);
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_err",   32'(bus.m_err),   32'd0);
    chk("rst_rdata", 32'(bus.m_rdata), 32'd0);
    chk("rst_sreq",  32'(bus.s_req),   32'd0);
    chk("rst_srw",   32'(bus.s_rw),    32'd0);
    chk("rst_saddr", 32'(bus.s_addr),  32'd0);
    chk("rst_swd",   32'(bus.s_wdata), 32'd0);
    rst_n    = 1'b1;
    last_srv = NUM_M - 1;
  endtask

  initial begin
    // Single read by master 2, slave answers after two BUSY cycles.
    do_reset();
    set_cmd(2, 1'b1, 8'h3C, 8'h00);
    drive_req(4'b0100);
    tick();
    chk("rd_sreq0",  32'(bus.s_req),   32'd1);
    chk("rd_saddr",  32'(bus.s_addr),  32'h3C);
    chk("rd_srw",    32'(bus.s_rw),    32'd1);
    chk("rd_gnt",    32'(bus.m_gnt),   32'b0100);
    chk("rd_nov0",   32'(bus.m_valid), 32'd0);
    tick();
    chk("rd_sreq1",  32'(bus.s_req),   32'd1);
    chk("rd_nov1",   32'(bus.m_valid), 32'd0);
    bus.s_valid = 1'b1;
    bus.s_rdata = 8'hA5;
    tick();
    bus.s_valid = 1'b0;
    bus.s_rdata = 8'h00;
    chk("rd_valid",  32'(bus.m_valid), 32'b0100);
    chk("rd_rdata",  32'(bus.m_rdata), 32'hA5);
    chk("rd_err",    32'(bus.m_err),   32'd0);
    chk("rd_sreq2",  32'(bus.s_req),   32'd0);
    drive_req(4'b0000);
    tick();
    chk("rd_vdrop",  32'(bus.m_valid), 32'd0);
    chk("rd_gdrop",  32'(bus.m_gnt),   32'd0);

    // All masters request continuously with a zero-wait slave.
    do_reset();
    for (int m = 0; m < NUM_M; m++) set_cmd(m, 1'b1, 8'(8'h40 + m), 8'h00);
    drive_req(4'b1111);
    for (int t = 0; t < 5; t++) begin
      w = t % NUM_M;
      tick();
      chk("rr_gnt",   32'(bus.m_gnt),   32'(oh(w)));
      chk("rr_sreq",  32'(bus.s_req),   32'd1);
      chk("rr_saddr", 32'(bus.s_addr),  32'(8'h40 + w));
      bus.s_valid = 1'b1;
      bus.s_rdata = 8'(8'h90 + t);
      tick();
      bus.s_valid = 1'b0;
      chk("rr_valid", 32'(bus.m_valid), 32'(oh(w)));
      chk("rr_rdata", 32'(bus.m_rdata), 32'(8'h90 + t));
      tick();
      chk("rr_vone",  32'(bus.m_valid), 32'd0);
      chk("rr_sreq0", 32'(bus.s_req),   32'd0);
    end
    drive_req(4'b0000);
    tick();

    // Master 1 write while master 0 stays idle; bus fields then hold while idle.
    do_reset();
    set_cmd(0, 1'b1, 8'hEE, 8'hDD);
    set_cmd(1, 1'b0, 8'h10, 8'h77);
    drive_req(4'b0010);
    tick();
    chk("wr_srw",    32'(bus.s_rw),    32'd0);
    chk("wr_saddr",  32'(bus.s_addr),  32'h10);
    chk("wr_swdata", 32'(bus.s_wdata), 32'h77);
    chk("wr_gnt_b",  32'(bus.m_gnt),   32'b0010);
    bus.s_valid = 1'b1;
    bus.s_rdata = 8'h5A;
    tick();
    bus.s_valid = 1'b0;
    chk("wr_gnt_r",  32'(bus.m_gnt),   32'b0010);
    chk("wr_valid",  32'(bus.m_valid), 32'b0010);
    drive_req(4'b0000);
    tick();
    tick();
    tick();
    chk("idle_sreq", 32'(bus.s_req),   32'd0);
    chk("idle_hold", 32'(bus.s_addr),  32'h10);
    chk("idle_gnt",  32'(bus.m_gnt),   32'd0);

    // Timeout on master 1, then master 2 is served.
    do_reset();
    set_cmd(1, 1'b1, 8'h21, 8'h00);
    set_cmd(2, 1'b1, 8'h22, 8'h00);
    drive_req(4'b0110);
    tick();
    chk("to_gnt", 32'(bus.m_gnt), 32'b0010);
    hi   = 0;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < TIMEOUT + 4 && !seen; i++) begin
      if (bus.s_req === 1'b1) hi++;
      if (bus.m_valid !== {NUM_M{1'b0}}) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        tick();
      end
    end
    chk("to_seen",  32'(seen),          32'd1);
    chk("to_sreqn", 32'(hi),            32'(TIMEOUT));
    chk("to_lat",   32'(lat),           32'(TIMEOUT));
    chk("to_valid", 32'(bus.m_valid),   32'b0010);
    chk("to_err",   32'(bus.m_err),     32'd1);
    chk("to_rdata", 32'(bus.m_rdata),   32'hFF);
    drive_req(4'b0100);
    tick();
    chk("to_errdn", 32'(bus.m_err),     32'd0);
    tick();
    chk("to_next",  32'(bus.m_gnt),     32'b0100);
    chk("to_naddr", 32'(bus.s_addr),    32'h22);
    bus.s_valid = 1'b1;
    bus.s_rdata = 8'h11;
    tick();
    bus.s_valid = 1'b0;
    chk("to_nval",  32'(bus.m_valid),   32'b0100);
    chk("to_nerr",  32'(bus.m_err),     32'd0);
    drive_req(4'b0000);
    tick();

    // s_valid on the same edge the timeout would expire.
    do_reset();
    set_cmd(3, 1'b1, 8'h33, 8'h00);
    drive_req(4'b1000);
    tick();
    repeat (TIMEOUT - 1) tick();
    chk("race_sreq",  32'(bus.s_req),   32'd1);
    chk("race_nov",   32'(bus.m_valid), 32'd0);
    bus.s_valid = 1'b1;
    bus.s_rdata = 8'hC3;
    tick();
    bus.s_valid = 1'b0;
    chk("race_valid", 32'(bus.m_valid), 32'b1000);
    chk("race_err",   32'(bus.m_err),   32'd0);
    chk("race_rdata", 32'(bus.m_rdata), 32'hC3);
    drive_req(4'b0000);
    tick();

    // Asynchronous reset in the middle of BUSY.
    do_reset();
    set_cmd(2, 1'b1, 8'h52, 8'h00);
    set_cmd(0, 1'b1, 8'h50, 8'h00);
    drive_req(4'b0100);
    tick();
    tick();
    chk("mr_busy", 32'(bus.s_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_sreq",  32'(bus.s_req),   32'd0);
    chk("mr_gnt",   32'(bus.m_gnt),   32'd0);
    chk("mr_valid", 32'(bus.m_valid), 32'd0);
    drive_req(4'b0101);
    tick();
    chk("mr_hold",  32'(bus.m_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_first", 32'(bus.m_gnt),   32'b0001);
    chk("mr_addr",  32'(bus.s_addr),  32'h50);
    bus.s_valid = 1'b1;
    bus.s_rdata = 8'h0F;
    tick();
    bus.s_valid = 1'b0;
    chk("mr_done",  32'(bus.m_valid), 32'b0001);
    drive_req(4'b0000);
    tick();

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int t = 0; t < 80; t++) begin
      for (int m = 0; m < NUM_M; m++) begin
        if (!req_v[m] && ($urandom_range(0, 1) == 1)) begin
          set_cmd(m, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
          req_v[m] = 1'b1;
        end
      end
      if (req_v == {NUM_M{1'b0}}) begin
        c = int'($urandom_range(0, NUM_M - 1));
        set_cmd(c, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        req_v[c] = 1'b1;
      end
      drive_req(req_v);
      w = -1;
      for (int k = 1; k <= NUM_M; k++) begin
        c = (last_srv + k) % NUM_M;
        if (w < 0 && req_v[c]) w = c;
      end
      tick();
      chk("rnd_gnt",   32'(bus.m_gnt),   32'(oh(w)));
      chk("rnd_sreq",  32'(bus.s_req),   32'd1);
      chk("rnd_srw",   32'(bus.s_rw),    32'(cmd_rw[w]));
      chk("rnd_saddr", 32'(bus.s_addr),  32'(cmd_addr[w]));
      chk("rnd_swd",   32'(bus.s_wdata), 32'(cmd_wdata[w]));
      lat  = int'($urandom_range(0, TIMEOUT + 1));
      rd   = 8'($urandom);
      done = 1'b0;
      for (int b = 0; b < TIMEOUT && !done; b++) begin
        if (b > 0) chk("rnd_hold", 32'(bus.s_req), 32'd1);
        bus.s_valid = (b == lat);
        bus.s_rdata = (b == lat) ? rd : 8'($urandom);
        tick();
        if (b == lat || b == TIMEOUT - 1) done = 1'b1;
      end
      bus.s_valid = 1'b0;
      exp_err = (lat >= TIMEOUT);
      exp_rd  = exp_err ? 8'hFF : rd;
      chk("rnd_valid", 32'(bus.m_valid), 32'(oh(w)));
      chk("rnd_err",   32'(bus.m_err),   32'(exp_err));
      chk("rnd_rdata", 32'(bus.m_rdata), 32'(exp_rd));
      chk("rnd_sreq0", 32'(bus.s_req),   32'd0);
      last_srv = w;
      req_v[w] = 1'b0;
      drive_req(req_v);
      tick();
      chk("rnd_vdone", 32'(bus.m_valid), 32'd0);
      chk("rnd_gdone", 32'(bus.m_gnt),   32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
